cordic_rot_prerotate: RTL

Front-end feeder for the rotation-mode CORDIC pipeline; it sits directly upstream of stage 1. It accepts one vector (x, y) and a target angle per handshake, and folds targets outside ±π/2 into range with an exact ±90° pre-rotation. It optionally pre-scales x and y by the CORDIC gain inverse K≈0.60725 using a bit-serial shift-add multiplier. It then presents the result to stage 1 with angle_out = 0 and a one-cycle enable_out pulse.

---
 rtl/cordic_pkg.sv | 30 +++
 rtl/cordic_const_mult.sv | 40 ++++
 rtl/cordic_rot_prerotate.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, FSM state encoding and helpers for the CORDIC rotation front end.
package cordic_pkg;

  localparam logic [15:0] HALF_PI = 16'h4000;
  localparam logic [15:0] K_Q16   = 16'h9B75;
  localparam int          SAT_W   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    SCALE  = 2'd2,
    ISSUE  = 2'd3
  } state_e;

  // Two's-complement negate of a w-bit value carried in SAT_W bits; the most negative
  // w-bit value maps to the most positive one instead of wrapping back onto itself.
  function automatic logic signed [SAT_W-1:0] sat_neg(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] v_min;
    v_min = -$signed(SAT_W'(1'b1) << (w - 32'd1));
    if (v == v_min) begin
      sat_neg = ~v_min;
    end else begin
      sat_neg = -v;
    end
  endfunction

endpackage

// File: rtl/cordic_const_mult.sv
// Bit-serial multiply by K_Q16: one partial product per step, selected by the step index.
module cordic_const_mult
  import cordic_pkg::*;
#(
  parameter int data_width = 16,
  parameter int acc_width  = data_width + 17
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         i_clear,
  input  logic                         i_step,
  input  logic [3:0]                   i_cnt,
  input  logic signed [data_width-1:0] i_value,
  output logic signed [acc_width-1:0]  o_acc
);

  logic signed [acc_width-1:0] w_term;
  logic signed [acc_width-1:0] r_acc;

  // Sign-extended operand weighted by 2^cnt.
  always_comb begin
    w_term = acc_width'(i_value) <<< i_cnt;
  end

  // Accumulate the partial product whenever the matching K bit is set.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_step && K_Q16[i_cnt]) begin
      r_acc <= r_acc + w_term;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/cordic_rot_prerotate.sv
// CORDIC rotation front end: quadrant fold by an exact +/-90 degree turn, optional
// multiply by the gain inverse K, then a one-cycle issue strobe into stage 1.
module cordic_rot_prerotate
  import cordic_pkg::*;
#(
  parameter int data_width  = 16,
  parameter int angle_width = 16,
  parameter int prescale    = 1
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [data_width-1:0]  x_in,
  input  logic signed [data_width-1:0]  y_in,
  input  logic signed [angle_width-1:0] target_in,
  output logic signed [data_width-1:0]  x_vec_out,
  output logic signed [data_width-1:0]  y_vec_out,
  output logic signed [angle_width-1:0] angle_out,
  output logic signed [angle_width-1:0] target_angle_out,
  output logic                          enable_out,
  output logic                          busy
);

  localparam logic signed [angle_width-1:0] LP_HALF_PI     = angle_width'(HALF_PI);
  localparam logic signed [angle_width-1:0] LP_NEG_HALF_PI = -LP_HALF_PI;
  localparam int                            LP_ACC_W       = data_width + 17;
  localparam int                            LP_FRAC        = 16;
  localparam bit                            LP_PRESCALE    = (prescale != 0);

  state_e                         r_state;
  logic [3:0]                     r_cnt;
  logic signed [data_width-1:0]   r_x;
  logic signed [data_width-1:0]   r_y;
  logic signed [angle_width-1:0]  r_t;
  logic signed [data_width-1:0]   r_x_out;
  logic signed [data_width-1:0]   r_y_out;
  logic signed [angle_width-1:0]  r_angle_out;
  logic signed [angle_width-1:0]  r_target_out;
  logic                           r_enable;

  logic signed [data_width-1:0]   w_red_x;
  logic signed [data_width-1:0]   w_red_y;
  logic signed [angle_width-1:0]  w_red_t;
  logic signed [LP_ACC_W-1:0]     w_acc_x;
  logic signed [LP_ACC_W-1:0]     w_acc_y;
  logic                           w_clear;
  logic                           w_step;

  function automatic logic signed [data_width-1:0] neg_d(input logic signed [data_width-1:0] v);
    neg_d = data_width'(sat_neg(SAT_W'(v), data_width));
  endfunction

  // Fold the captured target into [-pi/2, pi/2]; exactly +/-pi/2 is left alone.
  always_comb begin
    w_red_x = r_x;
    w_red_y = r_y;
    w_red_t = r_t;
    if (r_t > LP_HALF_PI) begin
      w_red_x = neg_d(r_y);
      w_red_y = r_x;
      w_red_t = r_t - LP_HALF_PI;
    end else if (r_t < LP_NEG_HALF_PI) begin
      w_red_x = r_y;
      w_red_y = neg_d(r_x);
      w_red_t = r_t + LP_HALF_PI;
    end else begin
      w_red_x = r_x;
      w_red_y = r_y;
      w_red_t = r_t;
    end
  end

  assign w_clear = (r_state == REDUCE);
  assign w_step  = (r_state == SCALE);

  cordic_const_mult #(
    .data_width (data_width),
    .acc_width  (LP_ACC_W)
  ) u_mult_x (
    .clk     (clk),
    .nreset  (nreset),
    .i_clear (w_clear),
    .i_step  (w_step),
    .i_cnt   (r_cnt),
    .i_value (r_x),
    .o_acc   (w_acc_x)
  );

  cordic_const_mult #(
    .data_width (data_width),
    .acc_width  (LP_ACC_W)
  ) u_mult_y (
    .clk     (clk),
    .nreset  (nreset),
    .i_clear (w_clear),
    .i_step  (w_step),
    .i_cnt   (r_cnt),
    .i_value (r_y),
    .o_acc   (w_acc_y)
  );

  // Sequencer: capture, reduce, optional 16-step scale, then issue with registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_x          <= '0;
      r_y          <= '0;
      r_t          <= '0;
      r_x_out      <= '0;
      r_y_out      <= '0;
      r_angle_out  <= '0;
      r_target_out <= '0;
      r_enable     <= 1'b0;
    end else begin
      r_enable <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= x_in;
            r_y     <= y_in;
            r_t     <= target_in;
            r_state <= REDUCE;
          end else begin
            r_state <= IDLE;
          end
        end
        REDUCE: begin
          r_x   <= w_red_x;
          r_y   <= w_red_y;
          r_t   <= w_red_t;
          r_cnt <= 4'd0;
          if (LP_PRESCALE) begin
            r_state <= SCALE;
          end else begin
            r_state <= ISSUE;
          end
        end
        SCALE: begin
          if (r_cnt == 4'd15) begin
            r_state <= ISSUE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ISSUE: begin
          if (LP_PRESCALE) begin
            r_x_out <= data_width'(w_acc_x >>> LP_FRAC);
            r_y_out <= data_width'(w_acc_y >>> LP_FRAC);
          end else begin
            r_x_out <= r_x;
            r_y_out <= r_y;
          end
          r_target_out <= r_t;
          r_angle_out  <= '0;
          r_enable     <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready         = (r_state == IDLE);
  assign busy             = (r_state != IDLE);
  assign x_vec_out        = r_x_out;
  assign y_vec_out        = r_y_out;
  assign angle_out        = r_angle_out;
  assign target_angle_out = r_target_out;
  assign enable_out       = r_enable;

endmodule
